// File: rtl/memory_access_pkg.sv
// ---------------------------------------------------------------------------
// memory_access_pkg
//   Shared constants and types for the load/store front-end that sits in
//   front of memory_unit.
//
//   BYTE_WIDTH           : width of one addressable memory byte.
//   DEFAULT_MEMORY_BYTES : default number of implemented bytes.
//   state_t              : FSM state type, with the four state constants.
// ---------------------------------------------------------------------------
package memory_access_pkg;

  localparam int BYTE_WIDTH           = 8;
  localparam int DEFAULT_MEMORY_BYTES = 8;

  // Plain vector constants rather than an enum, so the encoding stays
  // visible on legacy waveform viewers and netlists.
  typedef logic [1:0] state_t;

  localparam state_t IDLE        = 2'd0;  // ready for a new request
  localparam state_t ACCESS_LOW  = 2'd1;  // first (or only) memory cycle
  localparam state_t ACCESS_HIGH = 2'd2;  // second byte of a misaligned word
  localparam state_t RESPOND     = 2'd3;  // holding the response for the core

endpackage

// File: rtl/byte_lane_extend.sv
// ---------------------------------------------------------------------------
// byte_lane_extend
//   Picks one byte lane out of a 16-bit memory word and widens it back to
//   16 bits, either sign- or zero-extended.
//
//   word        in  : 16-bit word returned by memory_unit.
//   lane        in  : which byte to take (address bit 0, little-endian).
//   sign_extend in  : 1 = replicate the byte's MSB, 0 = fill with zeros.
//   extended    out : selected byte in [7:0], extension in [15:8].
// ---------------------------------------------------------------------------
module byte_lane_extend
  import memory_access_pkg::*;
(
  input  logic [2*BYTE_WIDTH-1:0] word,
  input  logic                    lane,
  input  logic                    sign_extend,
  output logic [2*BYTE_WIDTH-1:0] extended
);

  logic [BYTE_WIDTH-1:0] selected;

  // Little-endian: the odd address holds the upper half of the word.
  assign selected = lane ? word[2*BYTE_WIDTH-1:BYTE_WIDTH] : word[BYTE_WIDTH-1:0];

  assign extended = {{BYTE_WIDTH{sign_extend & selected[BYTE_WIDTH-1]}}, selected};

endmodule

// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
//   Load/store front-end directly upstream of memory_unit. Takes one byte or
//   word request at a time from the core, range-checks it, drives the
//   memory_unit cycles needed to carry it out, and returns one response.
//
//   Misaligned word accesses are split into two byte accesses (low byte at
//   the request address, high byte at address+1). Byte loads are sign- or
//   zero-extended. Out-of-range requests never touch memory and answer with
//   response_error=1 after a single cycle.
//
//   Ports
//     clock, reset_n           : clock, synchronous active-low reset
//     request_valid/ready      : request handshake from the core
//     request_write            : 1 = store, 0 = load
//     request_word             : 1 = 16-bit, 0 = 8-bit
//     request_signed           : byte loads only, 1 = sign-extend
//     request_address/data     : byte address, store data (bytes use [7:0])
//     response_valid/ready     : response handshake back to the core
//     response_data            : load result, 0 for stores and errors
//     response_error           : request was out of range
//     memory_write             : to memory_unit write (never high in reset)
//     memory_select_byte       : to memory_unit select_byte
//     memory_address           : to memory_unit address
//     memory_input_data        : to memory_unit input_data
//     memory_output_data       : from memory_unit output_data (comb. read)
// ---------------------------------------------------------------------------
module memory_access_unit
  import memory_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MEMORY_BYTES  = DEFAULT_MEMORY_BYTES
) (
  input  logic                     clock,
  input  logic                     reset_n,

  input  logic                     request_valid,
  output logic                     request_ready,
  input  logic                     request_write,
  input  logic                     request_word,
  input  logic                     request_signed,
  input  logic [ADDRESS_WIDTH-1:0] request_address,
  input  logic [DATA_WIDTH-1:0]    request_data,

  output logic                     response_valid,
  input  logic                     response_ready,
  output logic [DATA_WIDTH-1:0]    response_data,
  output logic                     response_error,

  output logic                     memory_write,
  output logic                     memory_select_byte,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_input_data,
  input  logic [DATA_WIDTH-1:0]    memory_output_data
);

  localparam int PAD_WIDTH = DATA_WIDTH - BYTE_WIDTH;

  state_t state;

  // Request fields latched at the accept edge.
  logic                     req_write;
  logic                     req_word;
  logic                     req_signed;
  logic                     req_error;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0]    req_data;

  // Load result being assembled; cleared on accept so stores and errors
  // respond with zero without extra muxing.
  logic [DATA_WIDTH-1:0]    result;

  logic [ADDRESS_WIDTH:0]   last_address;
  logic                     out_of_range;
  logic                     misaligned_word;
  logic                     memory_write_raw;
  logic [DATA_WIDTH-1:0]    lane_extended;

  // -------------------------------------------------------------------------
  // Range check on the incoming request
  // -------------------------------------------------------------------------
  // One extra bit keeps the carry of address+word, so 0xFFFF+1 is caught as
  // an overflow instead of wrapping to address 0.
  assign last_address = {1'b0, request_address} + (ADDRESS_WIDTH + 1)'(request_word);

  assign out_of_range = last_address[ADDRESS_WIDTH]
                     || (last_address >= (ADDRESS_WIDTH + 1)'(MEMORY_BYTES));

  assign misaligned_word = req_word & req_address[0];

  // -------------------------------------------------------------------------
  // Drive memory_unit
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    memory_write_raw   = 1'b0;
    memory_select_byte = 1'b0;
    memory_address     = '0;
    memory_input_data  = '0;

    case (state)
      ACCESS_LOW: begin
        memory_write_raw = req_write;
        memory_address   = req_address;
        if (req_word && !req_address[0]) begin
          // Aligned word: one full-width cycle.
          memory_select_byte = 1'b0;
          memory_input_data  = req_data;
        end else begin
          // Byte access, or the low half of a misaligned word.
          memory_select_byte = 1'b1;
          memory_input_data  = {{PAD_WIDTH{1'b0}}, req_data[BYTE_WIDTH-1:0]};
        end
      end

      ACCESS_HIGH: begin
        memory_write_raw   = req_write;
        memory_select_byte = 1'b1;
        memory_address     = req_address + ADDRESS_WIDTH'(1);
        memory_input_data  = {{PAD_WIDTH{1'b0}}, req_data[DATA_WIDTH-1:BYTE_WIDTH]};
      end

      default: ;
    endcase
  end

  // Gated combinationally so a store in flight cannot land while reset_n is
  // low, even during the cycle in which the reset is being sampled.
  assign memory_write = memory_write_raw & reset_n;

  // Byte lane for whichever address is currently on the memory bus: the
  // request address in ACCESS_LOW, address+1 in ACCESS_HIGH.
  byte_lane_extend u_byte_lane_extend (
    .word        (memory_output_data),
    .lane        (memory_address[0]),
    .sign_extend (req_signed),
    .extended    (lane_extended)
  );

  // -------------------------------------------------------------------------
  // FSM and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_write   <= 1'b0;
      req_word    <= 1'b0;
      req_signed  <= 1'b0;
      req_error   <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request_valid) begin
            req_write   <= request_write;
            req_word    <= request_word;
            req_signed  <= request_signed;
            req_error   <= out_of_range;
            req_address <= request_address;
            req_data    <= request_data;
            result      <= '0;
            state       <= out_of_range ? RESPOND : ACCESS_LOW;
          end
        end

        ACCESS_LOW: begin
          if (!req_write) begin
            if (req_word && !req_address[0]) begin
              result <= memory_output_data;
            end else if (req_word) begin
              result[BYTE_WIDTH-1:0] <= lane_extended[BYTE_WIDTH-1:0];
            end else begin
              result <= lane_extended;
            end
          end
          state <= misaligned_word ? ACCESS_HIGH : RESPOND;
        end

        ACCESS_HIGH: begin
          if (!req_write) begin
            result[DATA_WIDTH-1:BYTE_WIDTH] <= lane_extended[BYTE_WIDTH-1:0];
          end
          state <= RESPOND;
        end

        RESPOND: begin
          if (response_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Handshake outputs
  // -------------------------------------------------------------------------
  assign request_ready  = (state == IDLE);
  assign response_valid = (state == RESPOND);
  assign response_error = (state == RESPOND) & req_error;
  assign response_data  = (state == RESPOND) ? result : '0;

endmodule
